// File: rtl/invaders_grid.sv
// invaders_grid: ROWS x COLS invader formation that marches, descends at the edges,
// speeds up with level, resolves bullet hits and reports cleared / landed outcomes.
// All outputs are registered (one-clock update). Optional macro: INVADERS_SPEEDUP_EN.
module invaders_grid #(
  parameter int COLS       = 20,
  parameter int ROWS       = 2,
  parameter int LINE_W     = 4,
  parameter int LAND_LINE  = 13,
  parameter int BASE_TICKS = 3600000,
  parameter int XW         = $clog2(COLS)
) (
  input  logic                   clk_36MHz,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             level,
  input  logic                   bullet_valid,
  input  logic [XW-1:0]          bullet_x,
  input  logic [LINE_W-1:0]      bullet_y,
  output logic [ROWS*COLS-1:0]   alive,
  output logic [LINE_W-1:0]      invaders_line,
  output logic                   direction,
  output logic                   hit,
  output logic                   running,
  output logic                   cleared,
  output logic                   landed
);

  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(BASE_TICKS + 1);

  // One-hot so each status output is a plain flop bit.
  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_RUN     = 4'b0010,
    S_CLEARED = 4'b0100,
    S_LANDED  = 4'b1000
  } state_t;

  function automatic logic [N-1:0] init_mask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (((i % COLS) % 2) == 0);
    return m;
  endfunction

  localparam logic [N-1:0] INIT_MASK = init_mask();

  state_t            state_q, state_d;
  logic [N-1:0]      alive_q, alive_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              dir_q, dir_d;
  logic              hit_q, hit_d;
  logic [2:0]        level_q, level_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [CW-1:0]     period;
  logic              step_now;
  logic              hit_found;
  logic [IW-1:0]     hit_idx;
  logic [IW-1:0]     cand_idx;
  logic [N-1:0]      surv;
  logic              edge_r, edge_l;
  int                top_row;

`ifdef INVADERS_SPEEDUP_EN
  logic fast_q, fast_d;

  function automatic int popcount(input logic [N-1:0] m);
    int n;
    n = 0;
    for (int i = 0; i < N; i++) n = n + int'(m[i]);
    return n;
  endfunction
`endif

  // Step period from the latched level (and the thinned-out speedup when enabled).
  always_comb begin
    period = CW'(BASE_TICKS >> level_q);
    if (period == '0) period = CW'(1);
`ifdef INVADERS_SPEEDUP_EN
    if (fast_q) begin
      period = period >> 1;
      if (period == '0) period = CW'(1);
    end
`endif
  end

  // ">=" rather than "==" so a period shrink past the current count steps at once.
  assign step_now = (state_q == S_RUN) && (cnt_q >= period - CW'(1));

  // Find the first row whose line matches the bullet and whose target column is alive.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    cand_idx  = '0;
    if (bullet_valid && ({1'b0, bullet_x} < (XW+1)'(COLS))) begin
      for (int r = 0; r < ROWS; r++) begin
        cand_idx = IW'(r * COLS) + IW'(bullet_x);
        if (!hit_found && (bullet_y == line_q + LINE_W'(r)) && alive_q[cand_idx]) begin
          hit_found = 1'b1;
          hit_idx   = cand_idx;
        end
      end
    end
  end

  // Next state: wave load, hit removal, march step, then cleared / landed evaluation.
  always_comb begin
    state_d = state_q;
    alive_d = alive_q;
    line_d  = line_q;
    dir_d   = dir_q;
    hit_d   = 1'b0;
    level_d = level_q;
    cnt_d   = cnt_q;
    surv    = alive_q;
    edge_r  = 1'b0;
    edge_l  = 1'b0;
    top_row = 0;
`ifdef INVADERS_SPEEDUP_EN
    fast_d  = fast_q;
`endif
    case (state_q)
      S_RUN: begin
        // Hit is resolved against pre-step positions; the survivors are then stepped.
        hit_d = hit_found;
        if (hit_found) surv[hit_idx] = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
          edge_r = edge_r | surv[r*COLS + COLS - 1];
          edge_l = edge_l | surv[r*COLS];
        end
        alive_d = surv;
        if (step_now) begin
          cnt_d = '0;
`ifdef INVADERS_SPEEDUP_EN
          fast_d = (popcount(surv) <= (N / 4));
`endif
          // Whole-vector shifts are safe: the edge column that would spill into the
          // neighbouring row is known to be empty whenever a shift happens.
          if (dir_q) begin
            if (edge_r) begin
              line_d = line_q + LINE_W'(1);
              dir_d  = 1'b0;
            end else begin
              alive_d = surv << 1;
            end
          end else begin
            if (edge_l) begin
              line_d = line_q + LINE_W'(1);
              dir_d  = 1'b1;
            end else begin
              alive_d = surv >> 1;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        for (int r = 0; r < ROWS; r++) begin
          if (|alive_d[r*COLS +: COLS]) top_row = r;
        end
        if (alive_d == '0) begin
          state_d = S_CLEARED;
        end else if ((int'(line_d) + top_row) >= LAND_LINE) begin
          state_d = S_LANDED;
        end
      end
      default: begin
        // IDLE, CLEARED and LANDED hold everything frozen until the next start.
        if (start) begin
          state_d = S_RUN;
          alive_d = INIT_MASK;
          line_d  = '0;
          dir_d   = 1'b1;
          cnt_d   = '0;
          level_d = level;
`ifdef INVADERS_SPEEDUP_EN
          fast_d  = 1'b0;
`endif
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_36MHz or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      alive_q <= '0;
      line_q  <= '0;
      dir_q   <= 1'b1;
      hit_q   <= 1'b0;
      level_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
      line_q  <= line_d;
      dir_q   <= dir_d;
      hit_q   <= hit_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef INVADERS_SPEEDUP_EN
  // Speedup flag, refreshed only at counter wraps.
  always_ff @(posedge clk_36MHz or posedge reset) begin
    if (reset) fast_q <= 1'b0;
    else       fast_q <= fast_d;
  end
`endif

  assign alive         = alive_q;
  assign invaders_line = line_q;
  assign direction     = dir_q;
  assign hit           = hit_q;
  assign running       = state_q[1];
  assign cleared       = state_q[2];
  assign landed        = state_q[3];

endmodule

// File: tb/tb_invaders_grid.sv
// Bench for invaders_grid with BASE_TICKS=128: march/descend/land timing, level latching,
// a table of bullet vectors through a scoreboard, full clear, hit+step and async reset.
module tb_invaders_grid;

  localparam int COLS = 20;
  localparam int ROWS = 2;
  localparam int N    = 40;
  localparam int XW   = 5;
  localparam int LW   = 4;
  localparam logic [N-1:0] FULL_L = 40'h55_5555_5555;
  localparam logic [N-1:0] FULL_R = 40'hAA_AAAA_AAAA;

  logic          clk_36MHz;
  logic          reset;
  logic          start;
  logic [2:0]    level;
  logic          bullet_valid;
  logic [XW-1:0] bullet_x;
  logic [LW-1:0] bullet_y;
  logic [N-1:0]  alive;
  logic [LW-1:0] invaders_line;
  logic          direction;
  logic          hit;
  logic          running;
  logic          cleared;
  logic          landed;

  invaders_grid #(.BASE_TICKS(128)) dut (
    .clk_36MHz    (clk_36MHz),
    .reset        (reset),
    .start        (start),
    .level        (level),
    .bullet_valid (bullet_valid),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .alive        (alive),
    .invaders_line(invaders_line),
    .direction    (direction),
    .hit          (hit),
    .running      (running),
    .cleared      (cleared),
    .landed       (landed)
  );

  initial clk_36MHz = 1'b0;
  always #5 clk_36MHz = ~clk_36MHz;

  typedef struct packed {
    logic         hit;
    logic [N-1:0] alive;
  } exp_t;

  typedef struct {
    logic          vld;
    logic [XW-1:0] x;
    logic [LW-1:0] y;
    logic          exp_hit;
    logic [N-1:0]  exp_alive;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_36MHz);
    #1;
  endtask

  task automatic do_start(input logic [2:0] lvl);
    level = lvl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive one bullet, queue its expectation, and compare once the edge has produced output.
  task automatic apply(input logic v, input logic [XW-1:0] x, input logic [LW-1:0] y,
                       input logic eh, input logic [N-1:0] ea);
    exp_t e;
    bullet_valid = v;
    bullet_x     = x;
    bullet_y     = y;
    sb_q.push_back('{hit: eh, alive: ea});
    tick();
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      check("sb_hit", 64'(hit), 64'(e.hit));
      check("sb_alive", 64'(alive), 64'(e.alive));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] m1, m2, m3, m4, em;
    logic [5:0]   idx;
    int           cyc;

    m1 = FULL_L & ~(40'h1 << 22);
    m2 = m1 & ~40'h1;
    m3 = m2 & ~(40'h1 << 18);
    m4 = m3 & ~(40'h1 << 38);
    vecs[0] = '{vld: 1'b1, x: 5'd2,  y: 4'd1, exp_hit: 1'b1, exp_alive: m1};
    vecs[1] = '{vld: 1'b1, x: 5'd2,  y: 4'd1, exp_hit: 1'b0, exp_alive: m1};
    vecs[2] = '{vld: 1'b0, x: 5'd0,  y: 4'd0, exp_hit: 1'b0, exp_alive: m1};
    vecs[3] = '{vld: 1'b1, x: 5'd20, y: 4'd0, exp_hit: 1'b0, exp_alive: m1};
    vecs[4] = '{vld: 1'b1, x: 5'd24, y: 4'd0, exp_hit: 1'b0, exp_alive: m1};
    vecs[5] = '{vld: 1'b1, x: 5'd1,  y: 4'd0, exp_hit: 1'b0, exp_alive: m1};
    vecs[6] = '{vld: 1'b1, x: 5'd0,  y: 4'd0, exp_hit: 1'b1, exp_alive: m2};
    vecs[7] = '{vld: 1'b1, x: 5'd4,  y: 4'd2, exp_hit: 1'b0, exp_alive: m2};
    vecs[8] = '{vld: 1'b1, x: 5'd18, y: 4'd0, exp_hit: 1'b1, exp_alive: m3};
    vecs[9] = '{vld: 1'b1, x: 5'd18, y: 4'd1, exp_hit: 1'b1, exp_alive: m4};

    reset = 1'b1; start = 1'b0; level = 3'd0;
    bullet_valid = 1'b0; bullet_x = '0; bullet_y = '0;
    tick(); tick();
    check("rst_alive", 64'(alive), 64'h0);
    check("rst_line", 64'(invaders_line), 64'h0);
    check("rst_dir", 64'(direction), 64'h1);
    check("rst_flags", 64'({hit, running, cleared, landed}), 64'h0);
    reset = 1'b0;
    tick();
    check("idle_running", 64'(running), 64'h0);

    // March from IDLE at level 0: shift at +128, descend at +256, land at +3072.
    do_start(3'd0);
    check("start_running", 64'(running), 64'h1);
    check("start_alive", 64'(alive), 64'(FULL_L));
    check("start_line_dir", 64'({invaders_line, direction}), 64'({4'd0, 1'b1}));
    repeat (127) tick();
    check("pre_step_alive", 64'(alive), 64'(FULL_L));
    tick();
    check("step1_alive", 64'(alive), 64'(FULL_R));
    check("step1_line", 64'(invaders_line), 64'h0);
    repeat (127) tick();
    check("pre_descend_line", 64'(invaders_line), 64'h0);
    tick();
    check("descend_line", 64'(invaders_line), 64'h1);
    check("descend_dir", 64'(direction), 64'h0);
    check("descend_alive", 64'(alive), 64'(FULL_R));
    cyc = 256;
    while (!landed && cyc < 5000) begin
      tick();
      cyc++;
    end
    check("land_cycle", 64'(cyc), 64'd3072);
    check("land_line", 64'(invaders_line), 64'd12);
    check("land_dir", 64'(direction), 64'h1);
    check("land_alive", 64'(alive), 64'(FULL_L));
    check("land_running", 64'(running), 64'h0);
    bullet_valid = 1'b1; bullet_x = 5'd0; bullet_y = 4'd12;
    tick();
    check("land_no_hit", 64'(hit), 64'h0);
    bullet_valid = 1'b0;
    repeat (300) tick();
    check("land_frozen", 64'({alive, invaders_line}), 64'({FULL_L, 4'd12}));
    check("land_still", 64'(landed), 64'h1);

    // Restart at level 3 (P=16); level change and start pulse during RUN are ignored.
    do_start(3'd3);
    level = 3'd0;
    check("l3_alive", 64'(alive), 64'(FULL_L));
    check("l3_flags", 64'({running, landed}), 64'b10);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    check("l3_pre_step", 64'(alive), 64'(FULL_L));
    tick();
    check("l3_step", 64'(alive), 64'(FULL_R));
    repeat (15) tick();
    check("l3_pre_descend", 64'(invaders_line), 64'h0);
    tick();
    check("l3_descend", 64'({invaders_line, direction}), 64'({4'd1, 1'b0}));

    // Asynchronous reset between edges.
    #3;
    reset = 1'b1;
    #1;
    check("arst_alive", 64'(alive), 64'h0);
    check("arst_line_dir", 64'({invaders_line, direction}), 64'({4'd0, 1'b1}));
    check("arst_flags", 64'({hit, running, cleared, landed}), 64'h0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("post_arst_idle", 64'(running), 64'h0);

    // Bullet vector table, then destroy everything left.
    do_start(3'd0);
    check("e_alive", 64'(alive), 64'(FULL_L));
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].vld, vecs[i].x, vecs[i].y, vecs[i].exp_hit, vecs[i].exp_alive);
    end
    em = m4;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        idx = 6'(r * COLS + c);
        if (em[idx]) begin
          em[idx] = 1'b0;
          apply(1'b1, 5'(c), 4'(r), 1'b1, em);
          check("clear_flag", 64'(cleared), 64'(em == '0));
        end
      end
    end
    check("cleared_running", 64'(running), 64'h0);
    bullet_valid = 1'b0;
    tick();
    check("cleared_hit_drop", 64'(hit), 64'h0);
    repeat (200) tick();
    check("cleared_frozen", 64'({alive, invaders_line, cleared}), 64'({40'h0, 4'd0, 1'b1}));

    // Hit on the same edge as a right shift.
    do_start(3'd0);
    check("f_reload", 64'({alive, running}), 64'({FULL_L, 1'b1}));
    repeat (127) tick();
    apply(1'b1, 5'd4, 4'd0, 1'b1, FULL_R & ~(40'h1 << 5));
    check("f_bit5", 64'(alive[5]), 64'h0);
    bullet_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/invaders_grid.md
# invaders_grid

Parametrised multi-row invader formation engine for the `invaders` game core. It holds a ROWS x COLS alive mask that marches horizontally, descends at the edges and speeds up with `level`. It resolves bullet hits against any row and reports cleared or landed outcomes. It sits between the player/bullet logic and the VGA renderer, generalising the single-row array, line counter and speed timer into one configurable block.

## Interface
- COLS, 20, columns per row (even, ≥4)
- ROWS, 2, rows in the formation (≥1)
- LINE_W, 4, width of line coordinates
- LAND_LINE, 13, line at which the formation has landed
- BASE_TICKS, 3600000, step period at level 0 in clocks (100 ms at 36 MHz; must be ≥128)
- XW, $clog2(COLS), bullet column width (derived)

Ports:
- clk_36MHz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a wave (level-sensitive, sampled each clock)
- level  in  3  difficulty, latched on start
- bullet_valid  in  1  bullet position is valid this clock
- bullet_x  in  XW  bullet column
- bullet_y  in  LINE_W  bullet line
- alive  out  ROWS*COLS  alive mask; bit r*COLS+c = row r, column c
- invaders_line  out  LINE_W  line of row 0; row r is at invaders_line+r
- direction  out  1  1 = moving right, 0 = moving left
- hit  out  1  one-cycle pulse per destroyed invader
- running  out  1  state RUN
- cleared  out  1  state CLEARED
- landed  out  1  state LANDED

## Operation
- States: IDLE, RUN, CLEARED, LANDED. Reset → IDLE.
- IDLE/CLEARED/LANDED + start=1 → RUN.
  - Load every row with alternating pattern (columns 0,2,4,…,COLS-2 alive).
  - invaders_line=0, direction=1, step counter=0, latch level.
- start is ignored in RUN.
- Step period P = max(BASE_TICKS >> level_latched, 1). The counter counts 0..P-1; a step occurs when it equals P-1, then it returns to 0.
- Step, direction=1:
  - If any row has column COLS-1 alive → descend: invaders_line+1, direction=0, no shift.
  - Otherwise shift all rows one column toward higher index.
- Step, direction=0: mirror rule using column 0.
- Hit: bullet_valid, bullet_x<COLS, and bullet_y==invaders_line+r for some r with alive[r*COLS+bullet_x]=1 → clear that bit and pulse hit.
  - At most one hit per clock.
  - bullet_x≥COLS is ignored.
- Hit and step on the same clock: the hit is resolved against the pre-step positions, then the surviving mask is stepped.
- After any update, evaluate in priority order:
  1. All alive bits 0 → CLEARED.
  2. Else invaders_line + (index of highest row with any alive bit) ≥ LAND_LINE → LANDED.
- Line arithmetic is LINE_W bits and must not wrap: LAND_LINE ≤ 2^LINE_W − ROWS.
- CLEARED and LANDED freeze alive, invaders_line and direction until the next start.

## Timing
- Reset values: alive=0, invaders_line=0, direction=1, hit=0, running=0, cleared=0, landed=0, counter=0.
- All outputs are registered. A hit sampled on edge k shows hit=1 and the cleared alive bit after edge k; hit returns to 0 the following cycle unless another hit occurs.
- start sampled on edge k → running=1 after edge k. The first step lands on edge k+P.
- State flags change on the same edge as the causing update.
- Asynchronous reset mid-wave returns everything to reset values immediately. No step or hit is completed.

## Configuration
- INVADERS_SPEEDUP_EN defined: P is additionally halved (floor, minimum 1) while the popcount of alive is ≤ (ROWS*COLS)/4. The check is re-evaluated at each counter wrap; the counter is not reset when P changes. If the counter already exceeds P-1, the step occurs on the next clock.
- Not defined: P depends only on the latched level. No popcount logic is present.

## Test plan
- Defaults, BASE_TICKS=128, level=0, start pulse:
  - Row 0 alive bits 0,2,…,18.
  - After 128 clocks: shifted to 1,3,…,19.
  - After 256 clocks: invaders_line=1, direction=0, no shift.
- level=3: steps every 16 clocks. A level change during RUN has no effect until the next start.
- invaders_line=0, bullet_valid with bullet_x=2, bullet_y=1: alive[22] clears and hit pulses for 1 cycle. Repeating the same bullet gives no second pulse.
- Hit on the same clock as a right shift at bullet_x=4, bullet_y=0: bit 4 is cleared before the shift, so bit 5 is 0 after the edge.
- Let the formation march: landed=1 once invaders_line+1 ≥ 13. Alive stays frozen; a later start reloads the wave.
- Destroy all 20 invaders → cleared=1 on the last hit's edge.
- With INVADERS_SPEEDUP_EN, after 10 kills the step period is 64 clocks.
- Assert reset mid-wave: all outputs return to reset values that cycle.
